// File: rtl/memory_writeback_block_if.sv
`default_nettype none
// ============================================================================
//  Module      : memory_writeback_block_if
//  Description : Commit-side bus of the Y86-64 memory/writeback stage.
//                Carries fetch/decode/execute results into the stage and
//                returns memory read data, register write strobes and the
//                architectural state (pc, stat, retired).
//                master : producer of instruction results (upstream / bench)
//                slave  : memory_writeback_block
//  Revision    : 1.0 - initial release
// ============================================================================
interface memory_writeback_block_if;
    // upstream -> stage
    logic        in_valid;
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [3:0]  rA;
    logic [3:0]  rB;
    logic [63:0] valA;
    logic [63:0] valB;
    logic [63:0] valC;
    logic [63:0] valE;
    logic [63:0] valP;
    logic        cnd;
    logic        imem_error;
    logic        func_error;
    // stage -> register file / upstream
    logic [63:0] valM;
    logic [3:0]  dstE;
    logic [3:0]  dstM;
    logic [63:0] wr_valE;
    logic [63:0] wr_valM;
    logic        wr_en_E;
    logic        wr_en_M;
    logic [63:0] pc;
    logic [2:0]  stat;
    logic [31:0] retired;

    modport master (
        output in_valid, icode, ifun, rA, rB, valA, valB, valC, valE, valP,
               cnd, imem_error, func_error,
        input  valM, dstE, dstM, wr_valE, wr_valM, wr_en_E, wr_en_M,
               pc, stat, retired
    );

    modport slave (
        input  in_valid, icode, ifun, rA, rB, valA, valB, valC, valE, valP,
               cnd, imem_error, func_error,
        output valM, dstE, dstM, wr_valE, wr_valM, wr_en_E, wr_en_M,
               pc, stat, retired
    );
endinterface
`default_nettype wire

// File: rtl/memory_writeback_block.sv
`default_nettype none
// ============================================================================
//  Module      : memory_writeback_block
//  Description : Y86-64 memory + writeback + PC-update stage with a private
//                byte-addressed little-endian data memory. Commits one
//                instruction per valid cycle, tracks the sticky status
//                (AOK/HLT/ADR/INS) and counts retired instructions.
//  Ports       : clk  - clock, all state updates on rising edge
//                rst  - synchronous active-high reset
//                bus  - memory_writeback_block_if.slave (instruction results
//                       in; valM, dstE/dstM, write strobes, pc, stat,
//                       retired out)
//  Parameters  : DMEM_BYTES - data memory size in bytes
//                RESET_PC   - pc value loaded at reset
//  Options     : ALIGN_CHECK_EN - when defined, any access whose address is
//                not 8-byte aligned raises an address fault.
//  Revision    : 1.0 - initial release
// ============================================================================
module memory_writeback_block #(
    parameter int          DMEM_BYTES = 1024,
    parameter logic [63:0] RESET_PC   = 64'h0
) (
    input  wire logic                  clk,
    input  wire logic                  rst,
    memory_writeback_block_if.slave    bus
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam int          c_aw       = $clog2(DMEM_BYTES);
    localparam logic [63:0] c_max_addr = 64'(DMEM_BYTES - 8);

    localparam logic [3:0] c_i_halt   = 4'h0;
    localparam logic [3:0] c_i_cmov   = 4'h2;
    localparam logic [3:0] c_i_irmov  = 4'h3;
    localparam logic [3:0] c_i_rmmov  = 4'h4;
    localparam logic [3:0] c_i_mrmov  = 4'h5;
    localparam logic [3:0] c_i_opq    = 4'h6;
    localparam logic [3:0] c_i_jxx    = 4'h7;
    localparam logic [3:0] c_i_call   = 4'h8;
    localparam logic [3:0] c_i_ret    = 4'h9;
    localparam logic [3:0] c_i_push   = 4'hA;
    localparam logic [3:0] c_i_pop    = 4'hB;
    localparam logic [3:0] c_r_rsp    = 4'h4;
    localparam logic [3:0] c_r_none   = 4'hF;

    // status doubles as the stage state machine
    localparam logic [2:0] c_stat_aok = 3'd1;
    localparam logic [2:0] c_stat_hlt = 3'd2;
    localparam logic [2:0] c_stat_adr = 3'd3;
    localparam logic [2:0] c_stat_ins = 3'd4;

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    logic [7:0]  r_mem [DMEM_BYTES];
    logic [2:0]  r_stat;
    logic [63:0] r_pc;
    logic [31:0] r_retired;

    // ------------------------------------------------------------------
    // Decode of the memory access
    // ------------------------------------------------------------------
    logic          w_is_read;
    logic          w_is_write;
    logic          w_access;
    logic [63:0]   w_addr;
    logic [c_aw-1:0] w_base;
    logic          w_misaligned;
    logic          w_in_range;
    logic          w_dmem_error;
    logic [63:0]   w_wdata;
    logic [63:0]   w_rd_bytes;
    logic [63:0]   w_valm;

    assign w_is_read  = (bus.icode == c_i_mrmov) || (bus.icode == c_i_pop) ||
                        (bus.icode == c_i_ret);
    assign w_is_write = (bus.icode == c_i_rmmov) || (bus.icode == c_i_push) ||
                        (bus.icode == c_i_call);
    assign w_access   = w_is_read || w_is_write;

    // popq/ret read through the old stack pointer (valA); all others use valE
    assign w_addr  = ((bus.icode == c_i_pop) || (bus.icode == c_i_ret)) ? bus.valA : bus.valE;
    assign w_base  = w_addr[c_aw-1:0];
    assign w_wdata = (bus.icode == c_i_call) ? bus.valP : bus.valA;

    // full 64-bit compare so high addresses never alias into the array
    assign w_in_range = (w_addr <= c_max_addr);

`ifdef ALIGN_CHECK_EN
    assign w_misaligned = (w_addr[2:0] != 3'b000);
`else
    assign w_misaligned = 1'b0;
`endif

    assign w_dmem_error = w_access && (!w_in_range || w_misaligned);

    // Little-endian assembly, one byte lane at a time so unaligned
    // addresses work without a shifter.
    for (genvar gi = 0; gi < 8; gi++) begin : g_rd_byte
        assign w_rd_bytes[gi*8 +: 8] = r_mem[w_base + c_aw'(gi)];
    end

    // Out-of-range reads return zero rather than a meaningless alias.
    assign w_valm = (w_is_read && w_in_range) ? w_rd_bytes : 64'h0;

    // ------------------------------------------------------------------
    // Writeback destinations and next pc
    // ------------------------------------------------------------------
    logic [3:0]  w_dste;
    logic [3:0]  w_dstm;
    logic [63:0] w_next_pc;

    always_comb begin
        w_dste = c_r_none;
        case (bus.icode)
            c_i_irmov, c_i_opq:                     w_dste = bus.rB;
            c_i_cmov:                               w_dste = bus.cnd ? bus.rB : c_r_none;
            c_i_push, c_i_pop, c_i_call, c_i_ret:   w_dste = c_r_rsp;
            default:                                w_dste = c_r_none;
        endcase
    end

    assign w_dstm = ((bus.icode == c_i_mrmov) || (bus.icode == c_i_pop)) ? bus.rA : c_r_none;

    always_comb begin
        w_next_pc = bus.valP;
        case (bus.icode)
            c_i_call: w_next_pc = bus.valC;
            c_i_jxx:  w_next_pc = bus.cnd ? bus.valC : bus.valP;
            c_i_ret:  w_next_pc = w_valm;
            default:  w_next_pc = bus.valP;
        endcase
    end

    // ------------------------------------------------------------------
    // Fault classification (priority order); AOK means "would commit"
    // ------------------------------------------------------------------
    logic [2:0] w_fault_code;

    always_comb begin
        w_fault_code = c_stat_aok;
        if (bus.imem_error)
            w_fault_code = c_stat_adr;
        else if (bus.func_error || (bus.icode > c_i_pop))
            w_fault_code = c_stat_ins;
        else if (w_dmem_error)
            w_fault_code = c_stat_adr;
        else if (bus.icode == c_i_halt)
            w_fault_code = c_stat_hlt;
    end

    // ------------------------------------------------------------------
    // Status FSM: state register
    // ------------------------------------------------------------------
    logic [2:0] w_stat_next;

    always_ff @(posedge clk) begin
        if (rst)
            r_stat <= c_stat_aok;
        else
            r_stat <= w_stat_next;
    end

    // Status FSM: next state -- any non-AOK state is terminal until reset
    always_comb begin
        w_stat_next = r_stat;
        if ((r_stat == c_stat_aok) && bus.in_valid)
            w_stat_next = w_fault_code;
    end

    // Status FSM: outputs
    logic w_commit;
    logic w_wr_en_e;
    logic w_wr_en_m;

    always_comb begin
        w_commit  = bus.in_valid && (r_stat == c_stat_aok) && (w_fault_code == c_stat_aok);
        w_wr_en_e = w_commit && (w_dste != c_r_none);
        w_wr_en_m = w_commit && (w_dstm != c_r_none);
    end

    // ------------------------------------------------------------------
    // Architectural state
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc      <= RESET_PC;
            r_retired <= 32'd0;
        end else if (w_commit) begin
            r_pc      <= w_next_pc;
            r_retired <= r_retired + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DMEM_BYTES; i++)
                r_mem[i] <= 8'h00;
        end else if (w_commit && w_is_write) begin
            for (int k = 0; k < 8; k++)
                r_mem[w_base + c_aw'(k)] <= w_wdata[k*8 +: 8];
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.valM    = w_valm;
    assign bus.dstE    = w_dste;
    assign bus.dstM    = w_dstm;
    assign bus.wr_valE = bus.valE;
    assign bus.wr_valM = w_valm;
    assign bus.wr_en_E = w_wr_en_e;
    assign bus.wr_en_M = w_wr_en_m;
    assign bus.pc      = r_pc;
    assign bus.stat    = r_stat;
    assign bus.retired = r_retired;

    // ifun and valB are resolved upstream and carry no meaning here
    logic w_unused_ok;
    assign w_unused_ok = &{1'b0, bus.ifun, bus.valB};

endmodule
`default_nettype wire

// File: tb/tb_memory_writeback_block.sv
`default_nettype none
// ============================================================================
//  Module      : tb_memory_writeback_block
//  Description : Self-checking bench for memory_writeback_block. A table of
//                instruction records with expected results is replayed, then
//                hand-written sequences cover faults, halt, reset and
//                unaligned access (result depends on ALIGN_CHECK_EN).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_memory_writeback_block;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    memory_writeback_block_if bus ();

    memory_writeback_block #(
        .DMEM_BYTES (1024),
        .RESET_PC   (64'h0)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic        v;
        logic [3:0]  icode;
        logic [3:0]  ra;
        logic [3:0]  rb;
        logic [63:0] vala;
        logic [63:0] valc;
        logic [63:0] vale;
        logic [63:0] valp;
        logic        cnd;
        logic        ierr;
        logic        ferr;
        logic        chk_valm;
        logic [63:0] e_valm;
        logic [3:0]  e_dste;
        logic [3:0]  e_dstm;
        logic        e_wene;
        logic        e_wenm;
        logic [63:0] e_pc;
        logic [2:0]  e_stat;
        logic [31:0] e_ret;
    } vec_t;

    vec_t exp_q [$];
    vec_t tbl [14];
    int   checks   = 0;
    int   failures = 0;

    function automatic vec_t mk(input logic v, input logic [3:0] ic, input logic [3:0] ra,
                                input logic [3:0] rb, input logic [63:0] va, input logic [63:0] vc,
                                input logic [63:0] ve, input logic [63:0] vp, input logic cnd);
        vec_t t;
        t.v = v; t.icode = ic; t.ra = ra; t.rb = rb;
        t.vala = va; t.valc = vc; t.vale = ve; t.valp = vp; t.cnd = cnd;
        t.ierr = 1'b0; t.ferr = 1'b0;
        t.chk_valm = 1'b0; t.e_valm = '0; t.e_dste = 4'hF; t.e_dstm = 4'hF;
        t.e_wene = 1'b0; t.e_wenm = 1'b0; t.e_pc = '0; t.e_stat = 3'd1; t.e_ret = '0;
        return t;
    endfunction

    function automatic vec_t ex(input vec_t b, input logic cv, input logic [63:0] valm,
                                input logic [3:0] de, input logic [3:0] dm, input logic we,
                                input logic wm, input logic [63:0] pc, input logic [2:0] st,
                                input logic [31:0] rt);
        vec_t t;
        t = b;
        t.chk_valm = cv; t.e_valm = valm; t.e_dste = de; t.e_dstm = dm;
        t.e_wene = we; t.e_wenm = wm; t.e_pc = pc; t.e_stat = st; t.e_ret = rt;
        return t;
    endfunction

    task automatic chk(input string tag, input string what, input logic [63:0] act,
                       input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s.%s: got 0x%0h expected 0x%0h", tag, what, act, expv);
        end
    endtask

    task automatic drive_idle();
        bus.in_valid = 1'b0; bus.icode = 4'h1; bus.ifun = 4'h0; bus.rA = 4'hF; bus.rB = 4'hF;
        bus.valA = '0; bus.valB = '0; bus.valC = '0; bus.valE = '0; bus.valP = '0;
        bus.cnd = 1'b0; bus.imem_error = 1'b0; bus.func_error = 1'b0;
    endtask

    task automatic drive(input vec_t v);
        bus.in_valid = v.v; bus.icode = v.icode; bus.ifun = 4'h0; bus.rA = v.ra; bus.rB = v.rb;
        bus.valA = v.vala; bus.valB = 64'h0; bus.valC = v.valc; bus.valE = v.vale;
        bus.valP = v.valp; bus.cnd = v.cnd; bus.imem_error = v.ierr; bus.func_error = v.ferr;
    endtask

    // Drive one record, check combinational outputs mid-cycle, then the
    // registered state just after the commit edge.
    task automatic apply(input vec_t v, input string tag);
        vec_t e;
        drive(v);
        exp_q.push_back(v);
        @(negedge clk);
        e = exp_q.pop_front();
        if (e.chk_valm) chk(tag, "valM", bus.valM, e.e_valm);
        chk(tag, "dstE",    64'(bus.dstE),    64'(e.e_dste));
        chk(tag, "dstM",    64'(bus.dstM),    64'(e.e_dstm));
        chk(tag, "wr_en_E", 64'(bus.wr_en_E), 64'(e.e_wene));
        chk(tag, "wr_en_M", 64'(bus.wr_en_M), 64'(e.e_wenm));
        chk(tag, "wr_valE", bus.wr_valE,      e.vale);
        @(posedge clk);
        #1;
        chk(tag, "pc",      bus.pc,             e.e_pc);
        chk(tag, "stat",    64'(bus.stat),      64'(e.e_stat));
        chk(tag, "retired", 64'(bus.retired),   64'(e.e_ret));
        drive_idle();
    endtask

    task automatic do_reset();
        drive_idle();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        vec_t t;

        // inputs: v icode rA rB valA valC valE valP cnd
        // expect: chk_valm valM dstE dstM wenE wenM pc stat retired
        tbl[0]  = ex(mk(1, 4'h4, 4'h3, 4'h5, 64'h1122334455667788, 0, 64'h10, 64'h0A, 0),
                     1, 64'h0, 4'hF, 4'hF, 0, 0, 64'h0A, 1, 1);
        tbl[1]  = ex(mk(1, 4'h5, 4'h2, 4'hF, 0, 0, 64'h10, 64'h14, 0),
                     1, 64'h1122334455667788, 4'hF, 4'h2, 0, 1, 64'h14, 1, 2);
        tbl[2]  = ex(mk(1, 4'h8, 4'hF, 4'hF, 0, 64'h40, 64'h3F8, 64'h0A, 0),
                     1, 64'h0, 4'h4, 4'hF, 1, 0, 64'h40, 1, 3);
        tbl[3]  = ex(mk(1, 4'h9, 4'hF, 4'hF, 64'h3F8, 0, 64'h400, 64'h41, 0),
                     1, 64'h0A, 4'h4, 4'hF, 1, 0, 64'h0A, 1, 4);
        tbl[4]  = ex(mk(1, 4'h7, 4'hF, 4'hF, 0, 64'h80, 0, 64'h29, 0),
                     1, 64'h0, 4'hF, 4'hF, 0, 0, 64'h29, 1, 5);
        tbl[5]  = ex(mk(1, 4'h7, 4'hF, 4'hF, 0, 64'h80, 0, 64'h32, 1),
                     1, 64'h0, 4'hF, 4'hF, 0, 0, 64'h80, 1, 6);
        tbl[6]  = ex(mk(1, 4'h2, 4'h1, 4'h6, 64'h55, 0, 64'h55, 64'h82, 0),
                     1, 64'h0, 4'hF, 4'hF, 0, 0, 64'h82, 1, 7);
        tbl[7]  = ex(mk(1, 4'h2, 4'h1, 4'h6, 64'h55, 0, 64'h55, 64'h84, 1),
                     1, 64'h0, 4'h6, 4'hF, 1, 0, 64'h84, 1, 8);
        tbl[8]  = ex(mk(1, 4'h3, 4'hF, 4'h7, 0, 64'h5, 64'h5, 64'h8E, 0),
                     1, 64'h0, 4'h7, 4'hF, 1, 0, 64'h8E, 1, 9);
        tbl[9]  = ex(mk(1, 4'h6, 4'h1, 4'h2, 0, 0, 64'h77, 64'h90, 0),
                     1, 64'h0, 4'h2, 4'hF, 1, 0, 64'h90, 1, 10);
        tbl[10] = ex(mk(1, 4'hA, 4'h3, 4'hF, 64'hDEADBEEFCAFEF00D, 0, 64'h100, 64'h92, 0),
                     1, 64'h0, 4'h4, 4'hF, 1, 0, 64'h92, 1, 11);
        tbl[11] = ex(mk(1, 4'hB, 4'h4, 4'hF, 64'h100, 0, 64'h108, 64'h94, 0),
                     1, 64'hDEADBEEFCAFEF00D, 4'h4, 4'h4, 1, 1, 64'h94, 1, 12);
        tbl[12] = ex(mk(0, 4'h3, 4'hF, 4'h7, 0, 64'h9, 64'h9, 64'hAA, 0),
                     1, 64'h0, 4'h7, 4'hF, 0, 0, 64'h94, 1, 12);
        tbl[13] = ex(mk(1, 4'h1, 4'hF, 4'hF, 0, 0, 0, 64'h95, 0),
                     1, 64'h0, 4'hF, 4'hF, 0, 0, 64'h95, 1, 13);

        drive_idle();
        do_reset();
        @(negedge clk);
        chk("reset", "pc",      bus.pc, 64'h0);
        chk("reset", "stat",    64'(bus.stat), 64'd1);
        chk("reset", "retired", 64'(bus.retired), 64'd0);
        chk("reset", "wr_en_E", 64'(bus.wr_en_E), 64'd0);
        @(posedge clk);
        #1;

        for (int i = 0; i < 14; i++)
            apply(tbl[i], $sformatf("vec%0d", i));

        // unaligned read of bytes 0x13..0x1A
        t = mk(1, 4'h5, 4'h8, 4'hF, 0, 0, 64'h13, 64'h9F, 0);
`ifdef ALIGN_CHECK_EN
        apply(ex(t, 0, 64'h0, 4'hF, 4'h8, 0, 0, 64'h95, 3, 13), "unaligned");
`else
        apply(ex(t, 1, 64'h0000001122334455, 4'hF, 4'h8, 0, 1, 64'h9F, 1, 14), "unaligned");
`endif

        // out-of-range read near the top, then inputs ignored
        do_reset();
        apply(ex(mk(1, 4'h5, 4'h1, 4'hF, 0, 0, 64'h3FC, 64'h0A, 0),
                 0, 64'h0, 4'hF, 4'h1, 0, 0, 64'h0, 3, 0), "adr_top");
        apply(ex(mk(1, 4'h3, 4'hF, 4'h7, 0, 64'h1, 64'h1, 64'h0A, 0),
                 1, 64'h0, 4'h7, 4'hF, 0, 0, 64'h0, 3, 0), "sticky_adr");

        // address that would wrap if truncated
        do_reset();
        apply(ex(mk(1, 4'h5, 4'h1, 4'hF, 0, 0, 64'hFFFFFFFFFFFFFFF8, 64'h0A, 0),
                 0, 64'h0, 4'hF, 4'h1, 0, 0, 64'h0, 3, 0), "adr_wrap");

        // halt then nop
        do_reset();
        apply(ex(mk(1, 4'h0, 4'hF, 4'hF, 0, 0, 0, 64'h1, 0),
                 1, 64'h0, 4'hF, 4'hF, 0, 0, 64'h0, 2, 0), "halt");
        apply(ex(mk(1, 4'h1, 4'hF, 4'hF, 0, 0, 0, 64'h2, 0),
                 1, 64'h0, 4'hF, 4'hF, 0, 0, 64'h0, 2, 0), "nop_after_halt");

        // imem_error outranks func_error
        do_reset();
        t = mk(1, 4'h4, 4'h1, 4'h2, 64'h5, 0, 64'h20, 64'hA, 0);
        t.ierr = 1'b1; t.ferr = 1'b1;
        apply(ex(t, 0, 64'h0, 4'hF, 4'hF, 0, 0, 64'h0, 3, 0), "imem_func");

        // func_error alone, and illegal icode
        do_reset();
        t = mk(1, 4'h6, 4'h1, 4'h2, 0, 0, 64'h3, 64'h2, 0);
        t.ferr = 1'b1;
        apply(ex(t, 0, 64'h0, 4'h2, 4'hF, 0, 0, 64'h0, 4, 0), "func_err");
        do_reset();
        apply(ex(mk(1, 4'hC, 4'hF, 4'hF, 0, 0, 0, 64'h2, 0),
                 0, 64'h0, 4'hF, 4'hF, 0, 0, 64'h0, 4, 0), "bad_icode");

        // reset wins over a simultaneous commit; memory stays clear
        drive(mk(1, 4'h4, 4'h1, 4'h2, 64'hFFFF, 0, 64'h20, 64'h0A, 0));
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive_idle();
        chk("rst_commit", "pc",      bus.pc, 64'h0);
        chk("rst_commit", "retired", 64'(bus.retired), 64'd0);
        apply(ex(mk(1, 4'h5, 4'h1, 4'hF, 0, 0, 64'h20, 64'h0A, 0),
                 1, 64'h0, 4'hF, 4'h1, 0, 1, 64'h0A, 1, 1), "rst_mem_clear");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/memory_writeback_block.md
MEMORY_WRITEBACK_BLOCK -- requirements
Module: memory_writeback_block

Interface
REQ-001 Parameter DMEM_BYTES, 1024, data memory size in bytes (byte-addressed, little-endian).
REQ-002 Parameter RESET_PC, 0, PC value loaded at reset.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 in_valid  in  1  current fetch/decode/execute outputs valid for commit this cycle.
REQ-006 icode, ifun  in  4 each  instruction code/function from fetch.
REQ-007 rA, rB  in  4 each  register specifiers from fetch.
REQ-008 valA, valB, valC, valE, valP  in  64 each  operands from decode, fetch, execute.
REQ-009 cnd  in  1  condition result from execute.
REQ-010 imem_error, func_error  in  1 each  fetch error flags.
REQ-011 valM  out  64  memory read data, combinational.
REQ-012 dstE, dstM  out  4 each  writeback register IDs; 4'hF = none.
REQ-013 wr_valE, wr_valM  out  64 each  writeback data (valE, valM).
REQ-014 wr_en_E, wr_en_M  out  1 each  register file write strobes, sampled by the register file on the same edge.
REQ-015 pc  out  64  registered program counter.
REQ-016 stat  out  3  registered status: 1 AOK, 2 HLT, 3 ADR, 4 INS.
REQ-017 retired  out  32  registered count of committed instructions.

Function
REQ-018 Memory address: valE for rmmovq(4), mrmovq(5), pushq(A), call(8); valA for popq(B), ret(9); 8-byte accesses.
REQ-019 Write data: valA for rmmovq/pushq, valP for call; byte at addr holds bits [7:0].
REQ-020 Read: valM = 8 bytes at address for mrmovq/popq/ret, else 0.
REQ-021 dmem_error when an accessing instruction has address > DMEM_BYTES-8 (unsigned, full 64-bit compare, no wrap).
REQ-022 dstE: rB for irmovq(3), OPq(6), cmovXX(2) when cnd=1; 4 for pushq/popq/call/ret; else F.
REQ-023 dstM: rA for mrmovq/popq; else F.
REQ-024 Next PC: call -> valC; jXX(7) -> cnd ? valC : valP; ret -> valM; otherwise valP.
REQ-025 Fault priority: imem_error -> ADR, then func_error or icode > B -> INS, then dmem_error -> ADR, then halt(0) -> HLT.
REQ-026 commit = in_valid && stat==AOK && no fault && icode != halt.
REQ-027 On commit edge: memory write performed, pc <= next PC, retired <= retired+1 (wraps at 2^32-1 -> 0).
REQ-028 wr_en_E/wr_en_M = commit && dst != F; deasserted whenever commit=0.
REQ-029 On fault or halt edge with in_valid && stat==AOK: stat <= fault code; pc, memory, retired unchanged.
REQ-030 stat != AOK is sticky until reset; all further inputs ignored.
REQ-031 in_valid=0: no state change, no write strobes.
REQ-032 popq with rA=4: both strobes target rsp; register file gives M port priority (valM wins).

Reset
REQ-033 rst high at edge: pc <= RESET_PC, stat <= 1, retired <= 0, all memory bytes <= 0.
REQ-034 Reset overrides a simultaneous commit; no memory write or strobe-driven effect from that cycle is retained here.

Configuration
REQ-035 ALIGN_CHECK_EN defined: access with address[2:0] != 0 raises dmem_error (ADR).
REQ-036 ALIGN_CHECK_EN undefined: unaligned accesses permitted, bytes assembled individually.

Verification
REQ-037 Reset, then rmmovq valA=0x1122334455667788 valE=0x10, then mrmovq valE=0x10 rA=2 -> valM=0x1122334455667788, dstM=2, wr_en_M=1, retired=2.
REQ-038 call valC=0x40 valE=0x3F8 valP=0x0A -> bytes 0x3F8..0x3FF hold 0x0A, pc=0x40, dstE=4; then ret valA=0x3F8 -> pc=0x0A.
REQ-039 jXX cnd=0 valC=0x80 valP=0x29 -> pc=0x29; cmovXX cnd=0 -> wr_en_E=0.
REQ-040 mrmovq valE=0x3FC -> stat=3, pc unchanged, no strobes; further valid inputs ignored until rst.
REQ-041 halt then nop -> stat=2, retired unchanged; func_error plus imem_error together -> stat=3.
REQ-042 mrmovq valE=0x13: with ALIGN_CHECK_EN stat=3; without, valM from bytes 0x13..0x1A.
